// File: rtl/trap_sequencer.sv
// Machine-mode trap sequencer: takes an F- or E-stage exception or an MRET, writes
// mepc/mcause/mtval and MPP one CSR per cycle, then redirects the PC.
`ifndef XLEN_64b
`define XLEN_64b 2
`endif
`ifndef NO_E
`define NO_E                     4'hF
`define E_FETCH_ADDR_MISALIGNED  4'h0
`define E_FETCH_ACCESS_FAULT     4'h1
`define E_ILLEGAL_INSTR          4'h2
`define E_BREAKPOINT             4'h3
`define E_LOAD_ADDR_MISALIGNED   4'h4
`define E_LOAD_ACCESS_FAULT      4'h5
`define E_STORE_ADDR_MISALIGNED  4'h6
`define E_STORE_ACCESS_FAULT     4'h7
`define E_ECALL                  4'h8
`endif
`ifndef MACHINE
`define MACHINE                  2'b11
`endif

module trap_sequencer #(
   parameter int XLEN = `XLEN_64b
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic [3:0]                   i_exception_code_f,
   input  logic [3:0]                   i_exception_code_e,
   input  logic [(1 << (XLEN+4))-1:0]   i_pc_f,
   input  logic [(1 << (XLEN+4))-1:0]   i_pc_e,
   input  logic [(1 << (XLEN+4))-1:0]   i_alu_out_e,
   input  logic [(1 << (XLEN+4))-1:0]   i_mtvec,
   input  logic [(1 << (XLEN+4))-1:0]   i_mepc,
   input  logic                         i_mret_e,
   input  logic [1:0]                   i_mstatus_mpp,
   output logic                         o_csr_we,
   output logic [11:0]                  o_csr_addr,
   output logic [(1 << (XLEN+4))-1:0]   o_csr_wdata,
   output logic                         o_mpp_we,
   output logic [1:0]                   o_mpp_wdata,
   output logic                         o_pc_redirect_valid,
   output logic [(1 << (XLEN+4))-1:0]   o_pc_redirect,
   output logic                         o_flush,
   output logic                         o_stall,
   output logic [1:0]                   o_current_privilege,
   output logic                         o_disable_exceptions_1cc,
   output logic                         o_busy,
   output logic [2:0]                   o_dbg_state
);

   localparam int W = 1 << (XLEN + 4);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_SAVE_EPC   = 3'd1,
      S_SAVE_CAUSE = 3'd2,
      S_SAVE_TVAL  = 3'd3,
      S_REDIRECT   = 3'd4,
      S_MRET       = 3'd5
   } state_t;

   state_t         r_state;
   logic [W-1:0]   r_epc;
   logic [W-1:0]   r_cause;
   logic [W-1:0]   r_tval;
   logic [1:0]     r_priv;
   logic           r_dis;
   logic           r_run;

   logic           w_exc_e;
   logic           w_exc_f;
   logic [3:0]     w_code;
   logic [W-1:0]   w_mcause;
   logic [W-1:0]   w_tval;

   // r_run keeps detection (and o_flush) quiet while reset is held and for the first cycle after release.
   assign w_exc_e = r_run && !r_dis && (i_exception_code_e != `NO_E);
   assign w_exc_f = r_run && !r_dis && (i_exception_code_f != `NO_E);
   assign w_code  = w_exc_e ? i_exception_code_e : i_exception_code_f;

   always_comb begin
      w_mcause = {{(W-4){1'b0}}, w_code};
      if (w_code == `E_ECALL)
         w_mcause = W'(8) + W'(r_priv);
   end

   always_comb begin
      w_tval = '0;
      if (w_exc_e) begin
         case (i_exception_code_e)
            `E_LOAD_ADDR_MISALIGNED, `E_LOAD_ACCESS_FAULT,
            `E_STORE_ADDR_MISALIGNED, `E_STORE_ACCESS_FAULT: w_tval = i_alu_out_e;
            default:                                         w_tval = '0;
         endcase
      end else if (i_exception_code_f == `E_FETCH_ADDR_MISALIGNED) begin
         w_tval = i_pc_f;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_epc   <= '0;
         r_cause <= '0;
         r_tval  <= '0;
         r_priv  <= `MACHINE;
         r_dis   <= 1'b0;
         r_run   <= 1'b0;
      end else begin
         r_run <= 1'b1;
         case (r_state)
            S_IDLE: begin
               r_dis <= 1'b0;
               if (w_exc_e || w_exc_f) begin
                  r_epc   <= w_exc_e ? i_pc_e : i_pc_f;
                  r_cause <= w_mcause;
                  r_tval  <= w_tval;
                  r_state <= S_SAVE_EPC;
               end else if (r_run && i_mret_e) begin
                  r_state <= S_MRET;
               end
            end
            S_SAVE_EPC:   r_state <= S_SAVE_CAUSE;
            S_SAVE_CAUSE: r_state <= S_SAVE_TVAL;
            S_SAVE_TVAL:  r_state <= S_REDIRECT;
            S_REDIRECT: begin
               r_priv  <= `MACHINE;
               r_dis   <= 1'b1;
               r_state <= S_IDLE;
            end
            S_MRET: begin
               r_priv  <= i_mstatus_mpp;
               r_dis   <= 1'b1;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      o_csr_we                 = 1'b0;
      o_csr_addr               = '0;
      o_csr_wdata              = '0;
      o_mpp_we                 = 1'b0;
      o_mpp_wdata              = 2'b00;
      o_pc_redirect_valid      = 1'b0;
      o_pc_redirect            = '0;
      o_flush                  = 1'b0;
      o_stall                  = (r_state != S_IDLE);
      o_busy                   = (r_state != S_IDLE);
      o_current_privilege      = r_priv;
      o_disable_exceptions_1cc = r_dis;
      o_dbg_state              = r_state;
      case (r_state)
         S_IDLE:       o_flush = w_exc_e || w_exc_f;
         S_SAVE_EPC: begin
            o_csr_we    = 1'b1;
            o_csr_addr  = 12'h341;
            o_csr_wdata = {r_epc[W-1:2], 2'b00};
         end
         S_SAVE_CAUSE: begin
            o_csr_we    = 1'b1;
            o_csr_addr  = 12'h342;
            o_csr_wdata = r_cause;
         end
         S_SAVE_TVAL: begin
            o_csr_we    = 1'b1;
            o_csr_addr  = 12'h343;
            o_csr_wdata = r_tval;
            o_mpp_we    = 1'b1;
            o_mpp_wdata = r_priv;
         end
         S_REDIRECT: begin
            o_pc_redirect_valid = 1'b1;
            o_pc_redirect       = {i_mtvec[W-1:2], 2'b00};
            o_flush             = 1'b1;
         end
         S_MRET: begin
            o_pc_redirect_valid = 1'b1;
            o_pc_redirect       = i_mepc;
            o_flush             = 1'b1;
            o_mpp_we            = 1'b1;
            o_mpp_wdata         = 2'b00;
         end
         default: o_flush = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: per-cycle output checks plus an ordered queue of
// expected CSR writes consumed on the falling edge.
`ifndef NO_E
`define NO_E                     4'hF
`define E_FETCH_ADDR_MISALIGNED  4'h0
`define E_ILLEGAL_INSTR          4'h2
`define E_LOAD_ADDR_MISALIGNED   4'h4
`define E_ECALL                  4'h8
`endif

module tb_trap_sequencer;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic [3:0]  i_exception_code_f, i_exception_code_e;
   logic [63:0] i_pc_f, i_pc_e, i_alu_out_e, i_mtvec, i_mepc;
   logic        i_mret_e;
   logic [1:0]  i_mstatus_mpp;
   logic        o_csr_we, o_mpp_we, o_pc_redirect_valid, o_flush, o_stall;
   logic [11:0] o_csr_addr;
   logic [63:0] o_csr_wdata, o_pc_redirect;
   logic [1:0]  o_mpp_wdata, o_current_privilege;
   logic        o_disable_exceptions_1cc, o_busy;
   logic [2:0]  o_dbg_state;

   int n_cmp = 0;
   int n_err = 0;
   logic [75:0] exp_q[$];

   always #5 i_clk = ~i_clk;

   trap_sequencer dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_exception_code_f(i_exception_code_f), .i_exception_code_e(i_exception_code_e),
      .i_pc_f(i_pc_f), .i_pc_e(i_pc_e), .i_alu_out_e(i_alu_out_e),
      .i_mtvec(i_mtvec), .i_mepc(i_mepc), .i_mret_e(i_mret_e), .i_mstatus_mpp(i_mstatus_mpp),
      .o_csr_we(o_csr_we), .o_csr_addr(o_csr_addr), .o_csr_wdata(o_csr_wdata),
      .o_mpp_we(o_mpp_we), .o_mpp_wdata(o_mpp_wdata),
      .o_pc_redirect_valid(o_pc_redirect_valid), .o_pc_redirect(o_pc_redirect),
      .o_flush(o_flush), .o_stall(o_stall), .o_current_privilege(o_current_privilege),
      .o_disable_exceptions_1cc(o_disable_exceptions_1cc), .o_busy(o_busy),
      .o_dbg_state(o_dbg_state)
   );

   task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic csr_we, input logic [11:0] addr,
                             input logic [63:0] wdata, input logic mpp_we, input logic [1:0] mpp_wd,
                             input logic rv, input logic [63:0] rpc, input logic flush,
                             input logic busy, input logic [1:0] priv, input logic dis);
      chk({tag, ".csr_we"},   o_csr_we, csr_we);
      chk({tag, ".csr_addr"}, o_csr_addr, addr);
      chk({tag, ".csr_wdata"}, o_csr_wdata, wdata);
      chk({tag, ".mpp_we"},   o_mpp_we, mpp_we);
      chk({tag, ".mpp_wdata"}, o_mpp_wdata, mpp_wd);
      chk({tag, ".rd_valid"}, o_pc_redirect_valid, rv);
      chk({tag, ".rd_pc"},    o_pc_redirect, rpc);
      chk({tag, ".flush"},    o_flush, flush);
      chk({tag, ".stall"},    o_stall, busy);
      chk({tag, ".busy"},     o_busy, busy);
      chk({tag, ".priv"},     o_current_privilege, priv);
      chk({tag, ".dis1cc"},   o_disable_exceptions_1cc, dis);
   endtask

   task automatic next_cycle();
      @(posedge i_clk);
      #1;
   endtask

   // CSR write monitor: every write must match the head of the expected queue.
   always @(negedge i_clk) begin
      if (i_rst_n && o_csr_we) begin
         if (exp_q.size() == 0) chk("csr_extra", o_csr_we, 1'b0);
         else chk("csr_write", {o_csr_addr, o_csr_wdata}, exp_q.pop_front());
      end
   end

   initial begin
      i_rst_n = 1'b0;
      i_exception_code_f = `NO_E;
      i_exception_code_e = `E_ILLEGAL_INSTR;
      i_pc_f = '0; i_pc_e = '0; i_alu_out_e = '0; i_mtvec = '0; i_mepc = '0;
      i_mret_e = 1'b0; i_mstatus_mpp = 2'b00;
      repeat (2) next_cycle();
      expect_out("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 0);
      chk("reset.state", o_dbg_state, 3'd0);
      i_exception_code_e = `NO_E;
      i_rst_n = 1'b1;
      next_cycle(); next_cycle();
      #1 expect_out("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 0);

      // MRET from M with MPP=U
      i_mret_e = 1'b1; i_mepc = 64'h200; i_mstatus_mpp = 2'b00;
      #1 expect_out("mret_det", 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 0);
      next_cycle();
      i_mret_e = 1'b0;
      #1 expect_out("mret", 0, 0, 0, 1, 2'b00, 1, 64'h200, 1, 1, 2'b11, 0);
      next_cycle();
      #1 expect_out("mret_post", 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1);
      next_cycle();
      #1 expect_out("idle_u", 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);

      // E-stage load misaligned from U
      exp_q.push_back({12'h341, 64'h100});
      exp_q.push_back({12'h342, 64'h4});
      exp_q.push_back({12'h343, 64'h2002});
      i_exception_code_e = `E_LOAD_ADDR_MISALIGNED;
      i_pc_e = 64'h100; i_alu_out_e = 64'h2002; i_mtvec = 64'h801;
      #1 expect_out("ld_det", 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 0);
      next_cycle();
      i_exception_code_e = `NO_E; i_alu_out_e = '0;
      #1 expect_out("ld_epc", 1, 12'h341, 64'h100, 0, 0, 0, 0, 0, 1, 2'b00, 0);
      next_cycle();
      #1 expect_out("ld_cause", 1, 12'h342, 64'h4, 0, 0, 0, 0, 0, 1, 2'b00, 0);
      next_cycle();
      #1 expect_out("ld_tval", 1, 12'h343, 64'h2002, 1, 2'b00, 0, 0, 0, 1, 2'b00, 0);
      next_cycle();
      #1 expect_out("ld_redir", 0, 0, 0, 0, 0, 1, 64'h800, 1, 1, 2'b00, 0);
      next_cycle();

      // fetch exception pulse in the masked cycle after REDIRECT
      i_exception_code_f = `E_ILLEGAL_INSTR; i_pc_f = 64'h999;
      #1 expect_out("mask_cyc", 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 1);
      next_cycle();
      i_exception_code_f = `NO_E;
      #1 expect_out("mask_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 0);
      next_cycle();
      #1 expect_out("mask_after2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 0);

      // back to U
      i_mret_e = 1'b1; i_mepc = 64'h200; i_mstatus_mpp = 2'b00;
      next_cycle();
      i_mret_e = 1'b0;
      next_cycle(); next_cycle();
      #1 expect_out("back_u", 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);

      // simultaneous F illegal and E ecall from U: E wins
      exp_q.push_back({12'h341, 64'h3004});
      exp_q.push_back({12'h342, 64'h8});
      exp_q.push_back({12'h343, 64'h0});
      i_exception_code_f = `E_ILLEGAL_INSTR; i_pc_f = 64'h3008;
      i_exception_code_e = `E_ECALL; i_pc_e = 64'h3007; i_alu_out_e = 64'h55; i_mtvec = 64'h1003;
      #1 expect_out("ec_det", 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 0);
      next_cycle();
      i_exception_code_f = `NO_E; i_exception_code_e = `NO_E;
      #1 expect_out("ec_epc", 1, 12'h341, 64'h3004, 0, 0, 0, 0, 0, 1, 2'b00, 0);
      next_cycle();
      #1 expect_out("ec_cause", 1, 12'h342, 64'h8, 0, 0, 0, 0, 0, 1, 2'b00, 0);
      next_cycle();
      #1 expect_out("ec_tval", 1, 12'h343, 64'h0, 1, 2'b00, 0, 0, 0, 1, 2'b00, 0);
      next_cycle();
      #1 expect_out("ec_redir", 0, 0, 0, 0, 0, 1, 64'h1000, 1, 1, 2'b00, 0);
      next_cycle();

      // MRET honoured in the masked cycle
      i_mret_e = 1'b1; i_mepc = 64'h4000; i_mstatus_mpp = 2'b11;
      #1 expect_out("mask_mret", 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 1);
      next_cycle();
      i_mret_e = 1'b0;
      #1 expect_out("mask_mret_go", 0, 0, 0, 1, 2'b00, 1, 64'h4000, 1, 1, 2'b11, 0);
      next_cycle();
      #1 expect_out("mask_mret_post", 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 1);
      next_cycle();

      // F-stage fetch misaligned from M: tval = pc_f
      exp_q.push_back({12'h341, 64'h5000});
      exp_q.push_back({12'h342, 64'h0});
      exp_q.push_back({12'h343, 64'h5002});
      i_exception_code_f = `E_FETCH_ADDR_MISALIGNED; i_pc_f = 64'h5002; i_mtvec = 64'h800;
      #1 expect_out("fm_det", 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b11, 0);
      next_cycle();
      i_exception_code_f = `NO_E;
      #1 expect_out("fm_epc", 1, 12'h341, 64'h5000, 0, 0, 0, 0, 0, 1, 2'b11, 0);
      next_cycle();
      #1 expect_out("fm_cause", 1, 12'h342, 64'h0, 0, 0, 0, 0, 0, 1, 2'b11, 0);
      next_cycle();
      #1 expect_out("fm_tval", 1, 12'h343, 64'h5002, 1, 2'b11, 0, 0, 0, 1, 2'b11, 0);
      next_cycle();
      #1 expect_out("fm_redir", 0, 0, 0, 0, 0, 1, 64'h800, 1, 1, 2'b11, 0);
      next_cycle(); next_cycle();

      // ecall from M, reset dropped during SAVE_CAUSE
      exp_q.push_back({12'h341, 64'h6000});
      exp_q.push_back({12'h342, 64'd11});
      i_exception_code_e = `E_ECALL; i_pc_e = 64'h6000;
      #1 expect_out("rs_det", 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b11, 0);
      next_cycle();
      i_exception_code_e = `NO_E;
      next_cycle();
      #1 expect_out("rs_cause", 1, 12'h342, 64'd11, 0, 0, 0, 0, 0, 1, 2'b11, 0);
      @(negedge i_clk);
      #1 i_rst_n = 1'b0;
      #1 expect_out("rs_abort", 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 0);
      next_cycle();
      #1 expect_out("rs_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 0);
      i_rst_n = 1'b1;
      next_cycle(); next_cycle();
      #1 expect_out("rs_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 0);

      chk("csr_queue_left", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/trap_sequencer.md
TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default `XLEN_64b, meaning register width W = 1<<(XLEN+4) bits.
REQ-002 SHALL have ports i_clk (in, 1, sole clock) and i_rst_n (in, 1, reset, asynchronous and active-low).
REQ-003 SHALL have ports i_exception_code_f and i_exception_code_e (in, 4 each): fetch-stage and execute-stage exception codes, `NO_E when none.
REQ-004 SHALL have ports i_pc_f, i_pc_e, i_alu_out_e, i_mtvec and i_mepc (in, W each): stage PCs, E-stage memory address, and current CSR values.
REQ-005 SHALL have ports i_mret_e (in, 1, MRET in E) and i_mstatus_mpp (in, 2, current MPP field).
REQ-006 SHALL have outputs o_csr_we (1), o_csr_addr (12) and o_csr_wdata (W): the CSR write port.
REQ-007 SHALL have outputs o_mpp_we (1) and o_mpp_wdata (2): the MPP field write.
REQ-008 SHALL have outputs o_pc_redirect_valid (1) and o_pc_redirect (W).
REQ-009 SHALL have outputs o_flush (1, flush F/D/E), o_stall (1, hold F/D), o_current_privilege (2), o_disable_exceptions_1cc (1) and o_busy (1).

Function
REQ-010 SHALL implement FSM states IDLE, SAVE_EPC, SAVE_CAUSE, SAVE_TVAL, REDIRECT and MRET.
REQ-011 In IDLE with i_exception_code_e != `NO_E, SHALL capture cause=code_e, epc=i_pc_e and tval, assert o_flush that cycle, and go to SAVE_EPC.
REQ-012 tval for E-stage load/store misaligned or access fault SHALL be i_alu_out_e; for all other E codes it SHALL be 0.
REQ-013 In IDLE with code_e == `NO_E and code_f != `NO_E, SHALL capture cause=code_f and epc=i_pc_f; tval SHALL be i_pc_f for `E_FETCH_ADDR_MISALIGNED and 0 otherwise; SHALL assert o_flush and go to SAVE_EPC.
REQ-014 Priority SHALL be E exception > F exception > i_mret_e; in IDLE with no exception and i_mret_e=1, SHALL go to MRET.
REQ-015 When the captured cause is `E_ECALL, the mcause value SHALL be 8 + o_current_privilege at capture; all other codes SHALL be zero-extended to W.
REQ-016 SAVE_EPC SHALL drive o_csr_we=1, addr 0x341, data epc with bits [1:0] forced to 0.
REQ-017 SAVE_CAUSE SHALL drive o_csr_we=1, addr 0x342, data mcause.
REQ-018 SAVE_TVAL SHALL drive o_csr_we=1, addr 0x343, data tval, and o_mpp_we=1 with o_mpp_wdata = o_current_privilege.
REQ-019 REDIRECT SHALL drive o_pc_redirect_valid=1, o_pc_redirect={i_mtvec[W-1:2],2'b00} and o_flush=1, and SHALL load privilege `MACHINE on exit.
REQ-020 MRET (one cycle) SHALL drive o_pc_redirect_valid=1, o_pc_redirect=i_mepc, o_flush=1 and o_mpp_we=1 with o_mpp_wdata=2'b00, and SHALL load privilege from i_mstatus_mpp on exit.
REQ-021 Each of SAVE_EPC, SAVE_CAUSE, SAVE_TVAL, REDIRECT and MRET SHALL last exactly one cycle; SAVE_TVAL SHALL be followed by REDIRECT, and REDIRECT and MRET SHALL return to IDLE.
REQ-022 Trap latency SHALL be 5 cycles, from the detect cycle to the redirect cycle inclusive.
REQ-023 o_stall and o_busy SHALL be 1 in every non-IDLE state; all inputs SHALL be ignored outside IDLE.
REQ-024 o_disable_exceptions_1cc SHALL be 1 for exactly the first IDLE cycle after REDIRECT or MRET; in that cycle exception inputs SHALL be ignored, while i_mret_e is still honoured.
REQ-025 o_csr_we, o_mpp_we and o_pc_redirect_valid SHALL never be asserted in IDLE; o_csr_wdata and o_csr_addr SHALL be 0 whenever o_csr_we=0.

Reset
REQ-026 While i_rst_n=0 the block SHALL be in IDLE, with o_current_privilege=`MACHINE, all other outputs 0 and the captured epc/cause/tval cleared to 0.
REQ-027 Reset asserted mid-sequence SHALL abort immediately: no further CSR/MPP writes or redirect, and privilege returns to `MACHINE.

Verification
REQ-028 Privilege U, code_e=`E_LOAD_ADDR_MISALIGNED, i_pc_e=0x100, i_alu_out_e=0x2002, i_mtvec=0x801 -> 0x341<=0x100, 0x342<=4, 0x343<=0x2002, MPP<=0, redirect to 0x800, privilege M.
REQ-029 Same cycle: code_f=`E_ILLEGAL_INSTR and code_e=`E_ECALL with privilege U -> E wins, mcause=8, tval=0, epc=i_pc_e.
REQ-030 Privilege M, i_mret_e=1, i_mepc=0x200, i_mstatus_mpp=0 -> one-cycle redirect to 0x200, MPP<=0, privilege U next cycle.
REQ-031 code_f pulses on the cycle after REDIRECT -> ignored, o_disable_exceptions_1cc=1, no new trap.
REQ-032 i_rst_n dropped during SAVE_CAUSE -> no write to 0x343, no redirect, outputs at reset values.
